// File: rtl/cam_key_pkg.sv
// Shared types and helpers for the camouflage select-key loader.
package cam_key_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    ARMED,
    ERROR
  } cam_state_e;

  // Bit v of the nibble marks select value v as legal for that gate.
  function automatic logic sel_allowed(input logic [SEL_W-1:0] sel, input logic [3:0] nibble);
    return nibble[sel];
  endfunction

endpackage

// File: rtl/cam_key_loader_if.sv
// Serial key stream: load pulse plus a valid/ready bit handshake.
interface cam_key_loader_if;
  logic load_start;
  logic key_in_valid;
  logic key_in_bit;
  logic key_in_ready;

  modport master (
    output load_start,
    output key_in_valid,
    output key_in_bit,
    input  key_in_ready
  );

  modport slave (
    input  load_start,
    input  key_in_valid,
    input  key_in_bit,
    output key_in_ready
  );
endinterface

// File: rtl/cam_allow_check.sv
// Combinational legality check of every gate's 2-bit select against its allow nibble.
module cam_allow_check
  import cam_key_pkg::*;
#(
  parameter int unsigned               NUM_CAM = 1,
  parameter logic [4*NUM_CAM-1:0]      ALLOW   = {NUM_CAM{4'b1111}}
) (
  input  logic [SEL_W*NUM_CAM-1:0] shadow,
  output logic                     all_ok
);

  always_comb begin
    all_ok = 1'b1;
    for (int g = 0; g < int'(NUM_CAM); g++) begin
      if (!sel_allowed(shadow[g*SEL_W +: SEL_W], ALLOW[g*4 +: 4])) begin
        all_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_key_loader.sv
// Assembles a serial select key, checks it, and drives it steady into the camouflaged core.
module cam_key_loader
  import cam_key_pkg::*;
#(
  parameter int unsigned               NUM_CAM     = 1,
  parameter logic [4*NUM_CAM-1:0]      ALLOW       = {NUM_CAM{4'b1111}},
  parameter logic [SEL_W*NUM_CAM-1:0]  DEFAULT_SEL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cam_key_loader_if.slave          key_if,
  output logic [SEL_W*NUM_CAM-1:0] cam_sel,
  output logic                     key_valid,
  output logic                     key_err,
  output logic                     busy
);

  localparam int unsigned KeyW = SEL_W * NUM_CAM;
  localparam int unsigned CntW = $clog2(KeyW + 1);

  cam_state_e        state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [KeyW-1:0]   shadow_q, shadow_d;
  logic [KeyW-1:0]   cam_sel_q, cam_sel_d;
  logic              key_valid_q, key_valid_d;
  logic              key_err_q, key_err_d;
  logic              all_ok;
  logic              accept;

  cam_allow_check #(
    .NUM_CAM (NUM_CAM),
    .ALLOW   (ALLOW)
  ) u_allow_check (
    .shadow (shadow_q),
    .all_ok (all_ok)
  );

  assign accept = key_if.key_in_valid && (state_q == SHIFT);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    cam_sel_d   = cam_sel_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;

    // A new load discards any partial key but leaves cam_sel untouched.
    if (key_if.load_start) begin
      state_d     = SHIFT;
      count_d     = '0;
      shadow_d    = '0;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (accept) begin
            for (int i = 0; i < int'(KeyW); i++) begin
              if (count_q == CntW'(i)) shadow_d[i] = key_if.key_in_bit;
            end
            count_d = count_q + CntW'(1);
            if (count_q == CntW'(KeyW - 1)) state_d = CHECK;
          end
        end
        CHECK: begin
          if (all_ok) begin
            cam_sel_d   = shadow_q;
            key_valid_d = 1'b1;
            state_d     = ARMED;
          end else begin
            key_err_d = 1'b1;
            state_d   = ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      cam_sel_q   <= DEFAULT_SEL;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      cam_sel_q   <= cam_sel_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
    end
  end

  assign key_if.key_in_ready = (state_q == SHIFT);
  assign busy                = (state_q == SHIFT) || (state_q == CHECK);
  assign cam_sel             = cam_sel_q;
  assign key_valid           = key_valid_q;
  assign key_err             = key_err_q;

endmodule
